// File: rtl/instr_encoder_if.sv
// Symbolic-instruction handshake between a loader and instr_encoder.
// The master drives one instruction's fields; the slave answers with in_ready.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd,
    output in_shamt, in_funct, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd,
    input  in_shamt, in_funct, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instructions into MIPS words and writes them to
// consecutive instruction-memory addresses, one word per two cycles.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    src,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_full
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BGEZ = 6'b100111;
  localparam logic [5:0] OP_BALZ = 6'b011010;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  logic            last_q;
  logic [31:0]     enc;
  logic            legal;
  logic [5:0]      op;
  logic [ADDR_W:0] cnt_nxt;

  assign src.in_ready = (state == ACCEPT);
  assign cnt_nxt      = count + 1'b1;

  always_comb begin
    op    = 6'b0;
    legal = 1'b1;
    unique case (1'b1)
      (src.in_kind == 3'd0): op = 6'b0;
      (src.in_kind == 3'd1): op = OP_LW;
      (src.in_kind == 3'd2): op = OP_SW;
      (src.in_kind == 3'd3): op = OP_BEQ;
      (src.in_kind == 3'd4): op = OP_XORI;
      (src.in_kind == 3'd5): op = OP_BGEZ;
      (src.in_kind == 3'd6): op = OP_BALZ;
      default:               legal = 1'b0;
    endcase
  end

  always_comb begin
    if (src.in_kind == 3'd0)
      enc = {6'b0, src.in_rs, src.in_rt,
             src.in_rd, src.in_shamt, src.in_funct};
    else
      enc = {op, src.in_rs, src.in_rt, src.in_imm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_q      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_addr    <= base_addr;
            count       <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            busy        <= 1'b1;
            state       <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (src.in_valid) begin
            if (legal) begin
              mem_wdata <= enc;
              last_q    <= src.in_last;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              err_illegal <= 1'b1;
              if (src.in_last) begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        WRITE: begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + 1'b1;
          count    <= cnt_nxt;
          // capacity exhausted without in_last ends the session early
          if (last_q || cnt_nxt == DEPTH) begin
            done  <= 1'b1;
            state <= DONE;
            if (!last_q) err_full <= 1'b1;
          end else begin
            state <= ACCEPT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table-driven instructions with a write scoreboard,
// plus wrap/full (ADDR_W=2), reset-in-WRITE and start-while-busy sequences.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start2;
  logic [7:0]  base1;
  logic [1:0]  base2;
  logic        v, sel;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd, sh;
  logic [5:0]  fn;
  logic [15:0] imm;
  logic        last;

  instr_encoder_if if1();
  instr_encoder_if if2();

  assign if1.in_valid = v & ~sel;
  assign if2.in_valid = v & sel;
  assign if1.in_kind  = kind;
  assign if2.in_kind  = kind;
  assign if1.in_rs    = rs;
  assign if2.in_rs    = rs;
  assign if1.in_rt    = rt;
  assign if2.in_rt    = rt;
  assign if1.in_rd    = rd;
  assign if2.in_rd    = rd;
  assign if1.in_shamt = sh;
  assign if2.in_shamt = sh;
  assign if1.in_funct = fn;
  assign if2.in_funct = fn;
  assign if1.in_imm   = imm;
  assign if2.in_imm   = imm;
  assign if1.in_last  = last;
  assign if2.in_last  = last;

  wire rdy = sel ? if2.in_ready : if1.in_ready;

  logic        we1, busy1, done1, ei1, ef1;
  logic [7:0]  ad1;
  logic [31:0] wd1;
  logic [8:0]  cnt1;
  logic        we2, busy2, done2, ei2, ef2;
  logic [1:0]  ad2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;

  instr_encoder #(.ADDR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1),
    .src(if1), .mem_we(we1), .mem_addr(ad1), .mem_wdata(wd1),
    .busy(busy1), .done(done1), .count(cnt1),
    .err_illegal(ei1), .err_full(ef1)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base2),
    .src(if2), .mem_we(we2), .mem_addr(ad2), .mem_wdata(wd2),
    .busy(busy2), .done(done2), .count(cnt2),
    .err_illegal(ei2), .err_full(ef2)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        last;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tbl [11];
  wr_t  q1 [$];
  wr_t  q2 [$];
  int   acc [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rec = 1'b0;
  logic [7:0] exp_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (we1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_wr1: got addr %h data %h want none", ad1, wd1);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 32'(ad1), 32'(e.a));
        chk("wr1_data", wd1, e.d);
      end
    end
    if (we2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_wr2: got addr %h data %h want none", ad2, wd2);
      end else begin
        e = q2.pop_front();
        chk("wr2_addr", 32'(ad2), 32'(e.a));
        chk("wr2_data", wd2, e.d);
      end
    end
    if (rec && v && rdy) acc.push_back(cyc);
  end

  task automatic do_start(input bit s, input logic [7:0] b);
    @(negedge clk);
    sel = s;
    if (s) begin start2 = 1'b1; base2 = b[1:0]; end
    else   begin start1 = 1'b1; base1 = b; end
    exp_addr = s ? {6'b0, b[1:0]} : b;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    chk("ready_after_start", 32'(rdy), 32'd1);
  endtask

  task automatic send(input vec_t t, input bit keep, input bit push);
    int n = 0;
    kind = t.kind; rs = t.rs; rt = t.rt; rd = t.rd;
    sh = t.sh; fn = t.fn; imm = t.imm; last = t.last;
    v = 1'b1;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      chk("accept_timeout", 32'd0, 32'd1);
      v = 1'b0;
      return;
    end
    if (push && t.kind != 3'd7) begin
      if (sel) q2.push_back('{exp_addr, t.word});
      else     q1.push_back('{exp_addr, t.word});
      exp_addr = 8'((exp_addr + 8'd1) & (sel ? 8'h03 : 8'hFF));
    end
    @(posedge clk);
    #1;
    if (!keep) v = 1'b0;
  endtask

  task automatic wait_done(input int expc);
    int n = 0;
    logic d;
    d = sel ? done2 : done1;
    while (!d && n < 30) begin
      @(negedge clk);
      n++;
      d = sel ? done2 : done1;
    end
    chk("done_seen", 32'(d), 32'd1);
    chk("count", sel ? 32'(cnt2) : 32'(cnt1), 32'(expc));
    chk("busy_in_done", sel ? 32'(busy2) : 32'(busy1), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", sel ? 32'(done2) : 32'(done1), 32'd0);
    chk("busy_idle", sel ? 32'(busy2) : 32'(busy1), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{3'd1, 5'd2, 5'd3, 5'd7,  5'd9,  6'd5,  16'h0010, 1'b1, 32'h8C430010};
    tbl[1]  = '{3'd0, 5'd0, 5'd5, 5'd4,  5'd2,  6'd0,  16'hABCD, 1'b0, 32'h00052080};
    tbl[2]  = '{3'd4, 5'd1, 5'd1, 5'd9,  5'd0,  6'd0,  16'hFFFF, 1'b0, 32'h3821FFFF};
    tbl[3]  = '{3'd6, 5'd0, 5'd0, 5'd31, 5'd31, 6'd63, 16'h0004, 1'b0, 32'h68000004};
    tbl[4]  = '{3'd5, 5'd4, 5'd0, 5'd0,  5'd0,  6'd0,  16'hFFFE, 1'b1, 32'h9C80FFFE};
    tbl[5]  = '{3'd2, 5'd1, 5'd2, 5'd0,  5'd0,  6'd0,  16'h0008, 1'b0, 32'hAC220008};
    tbl[6]  = '{3'd7, 5'd3, 5'd3, 5'd3,  5'd3,  6'd3,  16'h1111, 1'b0, 32'h00000000};
    tbl[7]  = '{3'd2, 5'd3, 5'd4, 5'd0,  5'd0,  6'd0,  16'h000C, 1'b1, 32'hAC64000C};
    tbl[8]  = '{3'd3, 5'd1, 5'd2, 5'd0,  5'd0,  6'd0,  16'hFFFF, 1'b0, 32'h1022FFFF};
    tbl[9]  = '{3'd0, 5'd1, 5'd2, 5'd3,  5'd0,  6'h20, 16'h0000, 1'b0, 32'h00221820};
    tbl[10] = '{3'd4, 5'd2, 5'd3, 5'd0,  5'd0,  6'd0,  16'h1234, 1'b0, 32'h38431234};

    rst_n = 1'b1; start1 = 1'b0; start2 = 1'b0; base1 = '0; base2 = '0;
    v = 1'b0; sel = 1'b0; kind = '0; rs = '0; rt = '0; rd = '0;
    sh = '0; fn = '0; imm = '0; last = 1'b0; exp_addr = '0;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_ready", 32'(if1.in_ready), 32'd0);
    chk("rst_we", 32'(we1), 32'd0);
    chk("rst_addr", 32'(ad1), 32'd0);
    chk("rst_wdata", wd1, 32'd0);
    chk("rst_busy_done", {30'b0, busy1, done1}, 32'd0);
    chk("rst_count", 32'(cnt1), 32'd0);
    chk("rst_errs", {28'b0, ei1, ef1, ei2, ef2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single LW
    do_start(1'b0, 8'h10);
    send(tbl[0], 1'b0, 1'b1);
    wait_done(1);

    // mixed sequence from base 0 with in_valid held high
    do_start(1'b0, 8'h00);
    acc.delete();
    rec = 1'b1;
    for (int i = 1; i <= 4; i++) send(tbl[i], i < 4, 1'b1);
    rec = 1'b0;
    v = 1'b0;
    chk("bp_accepts", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++)
      chk("bp_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
    wait_done(4);

    // illegal kind between two SW words
    do_start(1'b0, 8'h20);
    for (int i = 5; i <= 7; i++) send(tbl[i], 1'b0, 1'b1);
    wait_done(2);
    chk("illegal_flag", 32'(ei1), 32'd1);
    chk("illegal_nofull", 32'(ef1), 32'd0);

    // wrap and full on the 4-word instance
    do_start(1'b1, 8'h03);
    acc.delete();
    rec = 1'b1;
    send(tbl[5],  1'b0, 1'b1);
    send(tbl[8],  1'b0, 1'b1);
    send(tbl[9],  1'b0, 1'b1);
    send(tbl[10], 1'b1, 1'b1);
    wait_done(4);
    rec = 1'b0;
    v = 1'b0;
    chk("full_accepts", 32'(acc.size()), 32'd4);
    chk("full_flag", 32'(ef2), 32'd1);
    chk("full_noillegal", 32'(ei2), 32'd0);

    // reset while in WRITE
    do_start(1'b0, 8'h50);
    send(tbl[5], 1'b0, 1'b0);
    chk("we_before_rst", 32'(we1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(we1), 32'd0);
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_ready", 32'(if1.in_ready), 32'd0);
    chk("rst_mid_count", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_start(1'b0, 8'h60);
    send(tbl[0], 1'b0, 1'b1);
    wait_done(1);

    // start while busy must not disturb the session
    do_start(1'b0, 8'h80);
    send(tbl[5], 1'b0, 1'b1);
    send(tbl[6], 1'b0, 1'b1);
    @(negedge clk);
    start1 = 1'b1;
    base1  = 8'h05;
    @(negedge clk);
    start1 = 1'b0;
    chk("busy_start_addr", 32'(ad1), 32'h81);
    chk("busy_start_count", 32'(cnt1), 32'd1);
    chk("busy_start_err", 32'(ei1), 32'd1);
    send(tbl[7], 1'b0, 1'b1);
    wait_done(2);
    chk("busy_start_err_end", 32'(ei1), 32'd1);

    repeat (3) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and program loader: the writer side of the opcode/control decoder. It accepts symbolic instructions one at a time over a valid/ready handshake and packs them into 32-bit MIPS-format words, using the same opcode set the control unit decodes. Each packed word is written into instruction memory at consecutive word addresses. It sits between the testbench or boot loader and the instruction-memory write port, so the single-cycle datapath can be loaded before it runs.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session (ignored unless state is IDLE)
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- in_kind  in  3  0 R-type, 1 LW, 2 SW, 3 BEQ, 4 XORI, 5 BGEZ, 6 BALZ, 7 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_funct  in  6  R-type function code
- in_imm  in  16  immediate or branch offset
- in_last  in  1  marks the final instruction of the session
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded instruction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the session ends
- count  out  ADDR_W+1  words written in the current session
- err_illegal  out  1  sticky; set when an illegal kind is received
- err_full  out  1  sticky; set when capacity is exhausted before in_last

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, XORI 001110, BGEZ 100111, BALZ 011010.
- Encoding for R-type: {6'b0, rs, rt, rd, shamt, funct}.
- Encoding for all other kinds: {op, rs, rt, imm}. Fields that a format does not use are ignored.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start: addr<=base_addr, count<=0, both err flags cleared, go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - When in_valid & in_ready with a legal kind: register the encoded word and in_last, go to WRITE.
  - When the kind is illegal: discard the word, set err_illegal, no write. Go to DONE if in_last is set, otherwise stay in ACCEPT.
- WRITE:
  - mem_we=1 for exactly one cycle, with mem_addr=addr and mem_wdata holding the registered word.
  - On the next edge: addr<=addr+1, wrapping modulo DEPTH, and count<=count+1.
  - Go to DONE if last was registered, or if the new count equals DEPTH. In the second case without last, set err_full.
  - Otherwise go back to ACCEPT.
- DONE: done=1 for one cycle, then IDLE. count, mem_wdata and the err flags hold their values until the next start.
- start while busy has no effect.
- The address wraps past DEPTH-1 to 0. A session never writes more than DEPTH words.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, err_illegal=0, err_full=0. State resets to IDLE.
- start sampled in cycle N → in_ready=1 in cycle N+1.
- Handshake in cycle N → mem_we=1 in cycle N+1 → in_ready=1 again in cycle N+2. Peak throughput is one word per 2 cycles.
- in_ready is 0 in WRITE, DONE and IDLE. Fields are sampled only on the handshake edge.
- Last word's write in cycle W → done pulses in W+1 → IDLE (busy=0) in W+2.
- Reset asserted mid-session: all outputs return to their reset values immediately and asynchronously. An in-flight mem_we is dropped. No partial write is allowed after rst_n rises.
- All outputs are registered except in_ready, which is decoded from the state register.

## Test plan
- Single LW, in_last=1:
  - Stimulus: base 0x10, LW with rs=2, rt=3, imm=0x0010, in_last=1.
  - Required: one write of 0x8C430010 at 0x10; done pulses; count=1.
- Mixed sequence from base 0:
  - Stimulus: SLL (rt=5, rd=4, shamt=2, funct=0); XORI (rs=1, rt=1, imm=0xFFFF); BALZ (imm=4); BGEZ (rs=4, imm=0xFFFE, in_last=1).
  - Required: words 0x00052080, 0x3821FFFF, 0x68000004, 0x9C80FFFE at addresses 0–3; count=4.
- Illegal kind:
  - Stimulus: kind 7 sent between two legal SW words.
  - Required: only 2 writes at consecutive addresses; err_illegal=1; no gap in addresses.
- Wrap and full with ADDR_W=2:
  - Stimulus: base 3, five legal words, none with in_last.
  - Required: writes land at addresses 3, 0, 1, 2; the fifth word is never accepted; err_full=1; done pulses; count=4.
- Backpressure and reset:
  - Stimulus: in_valid held high continuously.
  - Required: exactly one accept per 2 cycles.
  - Stimulus: rst_n pulled low during WRITE.
  - Required: mem_we falls immediately; busy=0; a following start restarts cleanly at the new base.
- start while busy:
  - Stimulus: start pulsed in ACCEPT with a different base_addr.
  - Required: addr, count and err flags unchanged.
